// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch controller states
//   NOP_INSTR     : instruction word presented to decode when no valid fetch
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,  // request outstanding on the memory port
        WAIT    = 2'd1,  // request accepted, waiting for read data
        HOLD    = 2'd2,  // instruction held and presented to decode
        DISCARD = 2'd3   // request accepted but its data must be dropped
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response port.
//   master : fetch side (drives imem_req/imem_addr)
//   slave  : memory side (drives imem_ready/imem_rvalid/imem_rdata)
interface fetch_stage_if;
    logic        imem_req;     // request valid
    logic [31:0] imem_addr;    // word-aligned fetch address
    logic        imem_ready;   // request accepted this cycle when imem_req=1
    logic        imem_rvalid;  // read data valid
    logic [31:0] imem_rdata;   // instruction word

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_holdreg.sv
// Enabled register used to hold a fetched instruction until decode takes it.
//   clk   : clock
//   reset : synchronous active-low reset, clears the register
//   en_i  : load enable
//   d_i   : data in
//   q_o   : registered data out
module fetch_holdreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time
// and presents the returned instruction to the decode pipeline register.
//   clk         : clock
//   reset       : synchronous active-low reset
//   StallD      : decode stalled, the presented instruction is not consumed
//   PCSrcD      : branch taken (resolved in decode)
//   PCBranchD   : branch target
//   imem        : instruction memory port (master side)
//   InstrF      : instruction to decode, NOP_INSTR when not valid
//   PCPlus4F    : PC+4 of the current PC
//   FetchValidF : InstrF carries a real fetched instruction
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallD,
    input  logic                 PCSrcD,
    input  logic [31:0]          PCBranchD,
    fetch_stage_if.master        imem,
    output logic [31:0]          InstrF,
    output logic [31:0]          PCPlus4F,
    output logic                 FetchValidF
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_instr;
    logic         hold_en;
    logic         redirect;
    logic [31:0]  branch_target;
    logic         unused_branch_lsbs;

    // A stalled decode cannot act on its branch decision.
    assign redirect           = PCSrcD & ~StallD;
    assign branch_target      = {PCBranchD[31:2], 2'b00};
    assign unused_branch_lsbs = ^PCBranchD[1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= {RESET_PC[31:2], 2'b00};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_en       = 1'b0;
        imem.imem_req = 1'b0;

        // A redirect always retargets the PC; the state only decides what
        // happens to an in-flight request.
        if (redirect) begin
            pc_d = branch_target;
        end

        case (state_q)
            FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ready) begin
                    state_d = redirect ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (redirect) begin
                        state_d = FETCH;
                    end else begin
                        hold_en = 1'b1;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (imem.imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (!StallD) begin
                    state_d = FETCH;
                    if (!redirect) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    fetch_holdreg #(
        .WIDTH (32)
    ) u_holdreg (
        .clk   (clk),
        .reset (reset),
        .en_i  (hold_en),
        .d_i   (imem.imem_rdata),
        .q_o   (hold_instr)
    );

    // The address simply follows the PC; the PC only moves on delivery or
    // redirect, so it is stable while a request waits for acceptance.
    assign imem.imem_addr = pc_q;
    assign PCPlus4F       = pc_q + 32'd4;
    assign FetchValidF    = (state_q == HOLD);
    assign InstrF         = (state_q == HOLD) ? hold_instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] InstrF, PCPlus4F;
    logic        FetchValidF;
    logic [31:0] InstrF2, PCPlus4F2;
    logic        FetchValidF2;

    fetch_stage_if mem_if ();
    fetch_stage_if mem2_if ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .StallD      (StallD),
        .PCSrcD      (PCSrcD),
        .PCBranchD   (PCBranchD),
        .imem        (mem_if.master),
        .InstrF      (InstrF),
        .PCPlus4F    (PCPlus4F),
        .FetchValidF (FetchValidF)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .StallD      (StallD),
        .PCSrcD      (PCSrcD),
        .PCBranchD   (PCBranchD),
        .imem        (mem2_if.master),
        .InstrF      (InstrF2),
        .PCPlus4F    (PCPlus4F2),
        .FetchValidF (FetchValidF2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        pcsrc;
        logic [31:0] br;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        fv;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    localparam int NVEC = 38;
    vec_t vecs [NVEC];

    int total_cnt = 0;
    int pass_cnt  = 0;

    localparam logic [31:0] A0   = 32'h1111_0001;
    localparam logic [31:0] A1   = 32'h2222_0002;
    localparam logic [31:0] A2   = 32'h3333_0003;
    localparam logic [31:0] B0   = 32'h4444_0004;
    localparam logic [31:0] B1   = 32'h5555_0005;
    localparam logic [31:0] C0   = 32'h6666_0006;
    localparam logic [31:0] E0   = 32'h7777_0007;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    function automatic vec_t mk(input logic rst, input logic stall, input logic pcsrc,
                                input logic [31:0] br, input logic rdy, input logic rv,
                                input logic [31:0] rdata, input logic req,
                                input logic [31:0] addr, input logic fv,
                                input logic [31:0] instr, input logic [31:0] pc4);
        vec_t v;
        v.rst = rst; v.stall = stall; v.pcsrc = pcsrc; v.br = br;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.req = req; v.addr = addr; v.fv = fv; v.instr = instr; v.pc4 = pc4;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        //               rst st ps br          rdy rv rdata  req addr          fv instr pc4
        vecs[0]  = mk(1, 0, 0, 32'h0,     1, 0, 32'h0, 1, 32'h0,     0, 32'h0, 32'h4);
        vecs[1]  = mk(1, 0, 0, 32'h0,     1, 1, A0,    0, 32'h0,     0, 32'h0, 32'h4);
        vecs[2]  = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 0, 32'h0,     1, A0,    32'h4);
        vecs[3]  = mk(1, 0, 0, 32'h0,     1, 0, 32'h0, 1, 32'h4,     0, 32'h0, 32'h8);
        vecs[4]  = mk(1, 0, 0, 32'h0,     0, 1, A1,    0, 32'h4,     0, 32'h0, 32'h8);
        vecs[5]  = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 0, 32'h4,     1, A1,    32'h8);
        vecs[6]  = mk(1, 0, 0, 32'h0,     1, 0, 32'h0, 1, 32'h8,     0, 32'h0, 32'hC);
        vecs[7]  = mk(1, 0, 0, 32'h0,     0, 1, A2,    0, 32'h8,     0, 32'h0, 32'hC);
        // decode stalled for four cycles while holding A2
        vecs[8]  = mk(1, 1, 0, 32'h0,     0, 0, 32'h0, 0, 32'h8,     1, A2,    32'hC);
        vecs[9]  = mk(1, 1, 1, 32'h500,   1, 1, DEAD,  0, 32'h8,     1, A2,    32'hC);
        vecs[10] = mk(1, 1, 0, 32'h0,     1, 0, 32'h0, 0, 32'h8,     1, A2,    32'hC);
        vecs[11] = mk(1, 1, 0, 32'h0,     1, 0, 32'h0, 0, 32'h8,     1, A2,    32'hC);
        vecs[12] = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 0, 32'h8,     1, A2,    32'hC);
        vecs[13] = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 1, 32'hC,     0, 32'h0, 32'h10);
        vecs[14] = mk(1, 0, 0, 32'h0,     1, 0, 32'h0, 1, 32'hC,     0, 32'h0, 32'h10);
        // redirect to 0x103 in WAIT, data returns two cycles later
        vecs[15] = mk(1, 0, 1, 32'h103,   0, 0, 32'h0, 0, 32'hC,     0, 32'h0, 32'h10);
        vecs[16] = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 0, 32'h100,   0, 32'h0, 32'h104);
        vecs[17] = mk(1, 0, 0, 32'h0,     0, 1, DEAD,  0, 32'h100,   0, 32'h0, 32'h104);
        vecs[18] = mk(1, 0, 0, 32'h0,     1, 0, 32'h0, 1, 32'h100,   0, 32'h0, 32'h104);
        vecs[19] = mk(1, 0, 0, 32'h0,     0, 1, B0,    0, 32'h100,   0, 32'h0, 32'h104);
        vecs[20] = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 0, 32'h100,   1, B0,    32'h104);
        // redirect on the accepting cycle in FETCH
        vecs[21] = mk(1, 0, 1, 32'h200,   1, 0, 32'h0, 1, 32'h104,   0, 32'h0, 32'h108);
        vecs[22] = mk(1, 0, 0, 32'h0,     0, 1, DEAD,  0, 32'h200,   0, 32'h0, 32'h204);
        vecs[23] = mk(1, 0, 0, 32'h0,     1, 0, 32'h0, 1, 32'h200,   0, 32'h0, 32'h204);
        vecs[24] = mk(1, 0, 0, 32'h0,     0, 1, B1,    0, 32'h200,   0, 32'h0, 32'h204);
        vecs[25] = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 0, 32'h200,   1, B1,    32'h204);
        // redirect in WAIT together with rvalid: straight back to FETCH
        vecs[26] = mk(1, 0, 0, 32'h0,     1, 0, 32'h0, 1, 32'h204,   0, 32'h0, 32'h208);
        vecs[27] = mk(1, 0, 1, 32'h300,   0, 1, DEAD,  0, 32'h204,   0, 32'h0, 32'h208);
        vecs[28] = mk(1, 0, 0, 32'h0,     0, 1, DEAD,  1, 32'h300,   0, 32'h0, 32'h304);
        vecs[29] = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 1, 32'h300,   0, 32'h0, 32'h304);
        // reset during WAIT, stale rvalid right after release
        vecs[30] = mk(1, 0, 0, 32'h0,     1, 0, 32'h0, 1, 32'h300,   0, 32'h0, 32'h304);
        vecs[31] = mk(0, 0, 0, 32'h0,     0, 0, 32'h0, 0, 32'h300,   0, 32'h0, 32'h304);
        vecs[32] = mk(1, 0, 0, 32'h0,     0, 1, DEAD,  1, 32'h0,     0, 32'h0, 32'h4);
        vecs[33] = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 1, 32'h0,     0, 32'h0, 32'h4);
        vecs[34] = mk(1, 0, 0, 32'h0,     1, 0, 32'h0, 1, 32'h0,     0, 32'h0, 32'h4);
        vecs[35] = mk(1, 0, 0, 32'h0,     0, 1, C0,    0, 32'h0,     0, 32'h0, 32'h4);
        vecs[36] = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 0, 32'h0,     1, C0,    32'h4);
        vecs[37] = mk(1, 0, 0, 32'h0,     0, 0, 32'h0, 1, 32'h4,     0, 32'h0, 32'h8);

        reset = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0;
        mem_if.imem_ready = 1'b0; mem_if.imem_rvalid = 1'b0; mem_if.imem_rdata = 32'h0;
        mem2_if.imem_ready = 1'b0; mem2_if.imem_rvalid = 1'b0; mem2_if.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);

        // Outputs checked reflect the current state; inputs act at the next edge.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            reset             = vecs[i].rst;
            StallD            = vecs[i].stall;
            PCSrcD            = vecs[i].pcsrc;
            PCBranchD         = vecs[i].br;
            mem_if.imem_ready  = vecs[i].rdy;
            mem_if.imem_rvalid = vecs[i].rv;
            mem_if.imem_rdata  = vecs[i].rdata;
            #1;
            $display("vec %0d: req=%b addr=%h fv=%b instr=%h pc4=%h", i,
                     mem_if.imem_req, mem_if.imem_addr, FetchValidF, InstrF, PCPlus4F);
            chk("imem_req",    i, {31'b0, mem_if.imem_req}, {31'b0, vecs[i].req});
            chk("imem_addr",   i, mem_if.imem_addr,         vecs[i].addr);
            chk("FetchValidF", i, {31'b0, FetchValidF},     {31'b0, vecs[i].fv});
            chk("InstrF",      i, InstrF,                   vecs[i].instr);
            chk("PCPlus4F",    i, PCPlus4F,                 vecs[i].pc4);
        end

        // PC wrap from RESET_PC = 0xFFFF_FFFC
        @(negedge clk);
        reset = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0;
        mem_if.imem_ready = 1'b0; mem_if.imem_rvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mem2_if.imem_ready = 1'b1;
        #1;
        $display("wrap reset: req=%b addr=%h pc4=%h", mem2_if.imem_req, mem2_if.imem_addr, PCPlus4F2);
        chk("wrap_req",   100, {31'b0, mem2_if.imem_req}, 32'h1);
        chk("wrap_addr",  100, mem2_if.imem_addr,         32'hFFFF_FFFC);
        chk("wrap_pc4",   100, PCPlus4F2,                 32'h0);
        chk("wrap_fv",    100, {31'b0, FetchValidF2},     32'h0);
        @(negedge clk);
        mem2_if.imem_ready = 1'b0; mem2_if.imem_rvalid = 1'b1; mem2_if.imem_rdata = E0;
        #1;
        $display("wrap wait: req=%b", mem2_if.imem_req);
        chk("wrap_wait_req", 101, {31'b0, mem2_if.imem_req}, 32'h0);
        @(negedge clk);
        mem2_if.imem_rvalid = 1'b0;
        #1;
        $display("wrap hold: fv=%b instr=%h pc4=%h", FetchValidF2, InstrF2, PCPlus4F2);
        chk("wrap_hold_fv",    102, {31'b0, FetchValidF2}, 32'h1);
        chk("wrap_hold_instr", 102, InstrF2,               E0);
        chk("wrap_hold_pc4",   102, PCPlus4F2,             32'h0);
        @(negedge clk);
        #1;
        $display("wrap second fetch: req=%b addr=%h pc4=%h", mem2_if.imem_req, mem2_if.imem_addr, PCPlus4F2);
        chk("wrap_next_req",  103, {31'b0, mem2_if.imem_req}, 32'h1);
        chk("wrap_next_addr", 103, mem2_if.imem_addr,         32'h0);
        chk("wrap_next_pc4",  103, PCPlus4F2,                 32'h4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
